// File: rtl/execute_m_pkg.sv
// -----------------------------------------------------------------------------
// execute_m_pkg
// Shared types and constants for the RV64IM execute stage:
//   mdu_op_e     - M-extension funct3 encodings
//   mdu_state_e  - iterative multiply/divide FSM states
//   BEQ..BGEU    - branch funct3 encodings used by the comparator
//   ALU_*        - ALUControl_E encodings understood by the alu block
// -----------------------------------------------------------------------------
package execute_m_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } mdu_state_e;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLT    = 4'd5;
    localparam logic [3:0] ALU_SLTU   = 4'd6;
    localparam logic [3:0] ALU_SLL    = 4'd7;
    localparam logic [3:0] ALU_SRL    = 4'd8;
    localparam logic [3:0] ALU_SRA    = 4'd9;
    localparam logic [3:0] ALU_SH1ADD = 4'd10;
    localparam logic [3:0] ALU_SH2ADD = 4'd11;
    localparam logic [3:0] ALU_SH3ADD = 4'd12;
    localparam logic [3:0] ALU_ADDUW  = 4'd13;
    localparam logic [3:0] ALU_PASSB  = 4'd14;

endpackage

// File: rtl/execute_m_alu.sv
// -----------------------------------------------------------------------------
// alu
// Single-cycle integer ALU including the Zba address-generation ops.
// Ports:
//   i_a, i_b     in  XLEN  operands
//   i_ctrl       in  4     operation (ALU_* in execute_m_pkg)
//   o_result     out XLEN  result
//   o_zero       out 1     result == 0
// -----------------------------------------------------------------------------
module alu
    import execute_m_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [3:0]      i_ctrl,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero
);

    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] w_shamt;
    logic [XLEN-1:0] w_result;

    assign w_shamt = i_b[SH_W-1:0];

    always_comb begin
        w_result = '0;
        case (i_ctrl)
            ALU_ADD:    w_result = i_a + i_b;
            ALU_SUB:    w_result = i_a - i_b;
            ALU_AND:    w_result = i_a & i_b;
            ALU_OR:     w_result = i_a | i_b;
            ALU_XOR:    w_result = i_a ^ i_b;
            ALU_SLT:    w_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU:   w_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            ALU_SLL:    w_result = i_a << w_shamt;
            ALU_SRL:    w_result = i_a >> w_shamt;
            ALU_SRA:    w_result = $unsigned($signed(i_a) >>> w_shamt);
            ALU_SH1ADD: w_result = (i_a << 1) + i_b;
            ALU_SH2ADD: w_result = (i_a << 2) + i_b;
            ALU_SH3ADD: w_result = (i_a << 3) + i_b;
            // add.uw zero-extends the low word of rs1 before adding
            ALU_ADDUW:  w_result = {{(XLEN-32){1'b0}}, i_a[31:0]} + i_b;
            ALU_PASSB:  w_result = i_b;
            default:    w_result = '0;
        endcase
    end

    assign o_result = w_result;
    assign o_zero   = (w_result == '0);

endmodule

// File: rtl/execute_m_mdu.sv
// -----------------------------------------------------------------------------
// mdu
// Iterative RV M-extension multiply/divide unit. One bit per cycle:
// shift-add multiply (2*XLEN-bit product) and restoring division, both on
// operand magnitudes with the result sign applied when the last bit lands.
// Divide-by-zero and signed overflow bypass the iteration and go straight
// to DONE.
// Ports:
//   clk, rst_n   in  1     clock, synchronous active-low reset
//   i_start      in  1     M-op present (only honoured in IDLE)
//   i_op         in  3     M funct3
//   i_a, i_b     in  XLEN  rs1 / rs2
//   o_busy       out 1     stall request: IDLE&start, MUL or DIV
//   o_done       out 1     result valid this cycle
//   o_result     out XLEN  result register
// -----------------------------------------------------------------------------
module mdu
    import execute_m_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0] r_hi;      // mul: product high half; div: partial remainder
    logic [XLEN-1:0] r_lo;      // mul: multiplier/product low; div: dividend/quotient
    logic [XLEN-1:0] r_opb;     // multiplicand or divisor magnitude
    logic            r_neg;     // final result must be negated
    logic            r_sel_hi;  // mul: return high half; div: return remainder
    logic [XLEN-1:0] r_result;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
        return cond_neg(v, is_signed & v[XLEN-1]);
    endfunction

    function automatic logic [XLEN-1:0] fix_mul(input logic [2*XLEN-1:0] prod,
                                                input logic neg, input logic sel_hi);
        logic [2*XLEN-1:0] p;
        p = neg ? (~prod + (2*XLEN)'(1)) : prod;
        return sel_hi ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
    endfunction

    // Operand decode in IDLE
    logic w_is_div, w_a_signed, w_b_signed, w_sa, w_sb;
    logic w_div0, w_ovf;

    always_comb begin
        w_is_div   = i_op[2];
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        if (w_is_div) begin
            // DIV/REM signed, DIVU/REMU unsigned
            w_a_signed = ~i_op[0];
            w_b_signed = ~i_op[0];
        end else begin
            w_a_signed = (i_op == OP_MULH) || (i_op == OP_MULHSU);
            w_b_signed = (i_op == OP_MULH);
        end
    end

    assign w_sa   = w_a_signed & i_a[XLEN-1];
    assign w_sb   = w_b_signed & i_b[XLEN-1];
    assign w_div0 = w_is_div & (i_b == '0);
    assign w_ovf  = w_is_div & ~i_op[0] & (i_a == MIN_NEG) & (i_b == '1);

    // One iteration step for each algorithm
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_hi_nxt, w_lo_nxt;
    logic            w_last;

    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_opb});
    // When w_ge holds the true difference is below the divisor, so the
    // XLEN-bit modular subtraction is exact.
    assign w_diff  = w_shift[XLEN-1:0] - r_opb;
    assign w_last  = (r_cnt == CNT_W'(XLEN-1));

    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_state == ST_MUL) begin
            w_hi_nxt = w_sum[XLEN:1];
            w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
        end else if (r_state == ST_DIV) begin
            w_hi_nxt = w_ge ? w_diff : w_shift[XLEN-1:0];
            w_lo_nxt = {r_lo[XLEN-2:0], w_ge};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (i_start) begin
                        if (w_div0) begin
                            r_result <= i_op[1] ? i_a : '1;
                            r_state  <= ST_DONE;
                        end else if (w_ovf) begin
                            r_result <= i_op[1] ? '0 : i_a;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state <= w_is_div ? ST_DIV : ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result <= fix_mul({w_hi_nxt, w_lo_nxt}, r_neg, r_sel_hi);
                        r_state  <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result <= cond_neg(r_sel_hi ? w_hi_nxt : w_lo_nxt, r_neg);
                        r_state  <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Datapath registers: latched at start, stepped while iterating
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE) begin
            r_hi  <= '0;
            r_lo  <= mag(i_a, w_a_signed);
            r_opb <= mag(i_b, w_b_signed);
            if (w_is_div) begin
                // quotient takes the xor of signs, remainder the dividend sign
                r_neg    <= i_op[1] ? w_sa : (w_sa ^ w_sb);
                r_sel_hi <= i_op[1];
            end else begin
                r_neg    <= w_sa ^ w_sb;
                r_sel_hi <= (i_op[1:0] != 2'b00);
            end
        end else begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
        end
    end

    assign o_busy   = ((r_state == ST_IDLE) & i_start) | (r_state == ST_MUL) | (r_state == ST_DIV);
    assign o_done   = (r_state == ST_DONE);
    assign o_result = r_result;

endmodule

// File: rtl/execute_m.sv
// -----------------------------------------------------------------------------
// execute_m
// RV64IM execute stage: ALU, funct3 branch comparator, JAL/JALR target
// generation and an iterative multiply/divide unit that stalls the pipeline.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   RD1_E, RD2_E, ImmExt_E, PC_E   operands from ID/EX
//   ALUControl_E, ALUSrc_E         ALU op and SrcB select (1 = immediate)
//   Branch_E, Jump_E, JumpReg_E    control-transfer type
//   BranchOp_E                     branch funct3
//   MDUStart_E, MDUOp_E            M-extension op present / funct3
//   ALUResult_E                    ALU result, MDU result in DONE cycle
//   WriteData_E                    store data (RD2_E)
//   PCTarget_E, PCSrc_E            redirect target / redirect enable
//   Zero_E                         ALU zero flag
//   Stall_E                        hold front end, bubble EX/MEM
// -----------------------------------------------------------------------------
module execute_m
    import execute_m_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] ImmExt_E,
    input  logic [XLEN-1:0] PC_E,
    input  logic [3:0]      ALUControl_E,
    input  logic            ALUSrc_E,
    input  logic            Branch_E,
    input  logic            Jump_E,
    input  logic            JumpReg_E,
    input  logic [2:0]      BranchOp_E,
    input  logic            MDUStart_E,
    input  logic [2:0]      MDUOp_E,
    output logic [XLEN-1:0] ALUResult_E,
    output logic [XLEN-1:0] WriteData_E,
    output logic [XLEN-1:0] PCTarget_E,
    output logic            PCSrc_E,
    output logic            Zero_E,
    output logic            Stall_E
);

    logic [XLEN-1:0] w_srcb;
    logic [XLEN-1:0] w_alu_result;
    logic            w_alu_zero;
    logic            w_mdu_busy;
    logic            w_mdu_done;
    logic [XLEN-1:0] w_mdu_result;
    logic            w_eq, w_lt, w_ltu, w_cond;
    logic [XLEN-1:0] w_jalr_sum;

    assign w_srcb = ALUSrc_E ? ImmExt_E : RD2_E;

    alu #(.XLEN(XLEN)) u_alu (
        .i_a      (RD1_E),
        .i_b      (w_srcb),
        .i_ctrl   (ALUControl_E),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    mdu #(.XLEN(XLEN)) u_mdu (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (MDUStart_E),
        .i_op     (MDUOp_E),
        .i_a      (RD1_E),
        .i_b      (RD2_E),
        .o_busy   (w_mdu_busy),
        .o_done   (w_mdu_done),
        .o_result (w_mdu_result)
    );

    // Branch comparator works on register operands regardless of ALUSrc_E
    assign w_eq  = (RD1_E == RD2_E);
    assign w_lt  = ($signed(RD1_E) < $signed(RD2_E));
    assign w_ltu = (RD1_E < RD2_E);

    always_comb begin
        w_cond = 1'b0;
        case (BranchOp_E)
            BEQ:     w_cond = w_eq;
            BNE:     w_cond = ~w_eq;
            BLT:     w_cond = w_lt;
            BGE:     w_cond = ~w_lt;
            BLTU:    w_cond = w_ltu;
            BGEU:    w_cond = ~w_ltu;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_jalr_sum  = RD1_E + ImmExt_E;
    assign PCTarget_E  = JumpReg_E ? {w_jalr_sum[XLEN-1:1], 1'b0} : (PC_E + ImmExt_E);
    assign PCSrc_E     = Jump_E | (Branch_E & w_cond);

    assign ALUResult_E = w_mdu_done ? w_mdu_result : w_alu_result;
    assign WriteData_E = RD2_E;
    assign Zero_E      = w_alu_zero;
    assign Stall_E     = w_mdu_busy;

endmodule

// File: tb/tb_execute_m.sv
module tb_execute_m;
    import execute_m_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] RD1_E, RD2_E, ImmExt_E, PC_E;
    logic [3:0]  ALUControl_E;
    logic        ALUSrc_E, Branch_E, Jump_E, JumpReg_E;
    logic [2:0]  BranchOp_E;
    logic        MDUStart_E;
    logic [2:0]  MDUOp_E;
    logic [63:0] ALUResult_E, WriteData_E, PCTarget_E;
    logic        PCSrc_E, Zero_E, Stall_E;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    execute_m #(.XLEN(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RD1_E        (RD1_E),
        .RD2_E        (RD2_E),
        .ImmExt_E     (ImmExt_E),
        .PC_E         (PC_E),
        .ALUControl_E (ALUControl_E),
        .ALUSrc_E     (ALUSrc_E),
        .Branch_E     (Branch_E),
        .Jump_E       (Jump_E),
        .JumpReg_E    (JumpReg_E),
        .BranchOp_E   (BranchOp_E),
        .MDUStart_E   (MDUStart_E),
        .MDUOp_E      (MDUOp_E),
        .ALUResult_E  (ALUResult_E),
        .WriteData_E  (WriteData_E),
        .PCTarget_E   (PCTarget_E),
        .PCSrc_E      (PCSrc_E),
        .Zero_E       (Zero_E),
        .Stall_E      (Stall_E)
    );

    task automatic clear_inputs();
        RD1_E = '0; RD2_E = '0; ImmExt_E = '0; PC_E = '0;
        ALUControl_E = ALU_ADD; ALUSrc_E = 1'b0;
        Branch_E = 1'b0; Jump_E = 1'b0; JumpReg_E = 1'b0; BranchOp_E = 3'b000;
        MDUStart_E = 1'b0; MDUOp_E = 3'b000;
    endtask

    // Starts an M-op in IDLE, counts Stall_E cycles, returns DONE-cycle result.
    // Leaves MDUStart_E high; the caller decides what happens after DONE.
    task automatic run_mdu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                           input bit scramble, output int stalls, output logic [63:0] res);
        @(posedge clk); #1;
        MDUOp_E = op; RD1_E = a; RD2_E = b; MDUStart_E = 1'b1;
        stalls = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (Stall_E) begin
                stalls++;
                if (scramble && stalls == 10) begin
                    RD1_E = 64'h1234_5678_9ABC_DEF0;
                    RD2_E = 64'h0FED_CBA9_8765_4321;
                end
            end else begin
                break;
            end
        end
        res = ALUResult_E;
    endtask

    task automatic mdu_stop();
        @(posedge clk); #1;
        MDUStart_E = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (Stall_E !== 1'b0) begin
            n_bad++; $display("FAIL reset_stall: got %b expected 0", Stall_E);
        end
        RD1_E = 64'd9; RD2_E = 64'd4; ALUControl_E = ALU_ADD;
        #1;
        n_vec++;
        if (ALUResult_E !== 64'd13) begin
            n_bad++; $display("FAIL reset_alu: got %h expected %h", ALUResult_E, 64'd13);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_inputs();
    endtask

    task automatic test_alu();
        logic [63:0] a [5];
        logic [63:0] b [5];
        logic [3:0]  c [5];
        logic        s [5];
        logic [63:0] e [5];
        logic        z [5];
        a[0] = 64'd5;              b[0] = 64'd10;  c[0] = ALU_ADD;    s[0] = 1'b1; e[0] = 64'd15;                 z[0] = 1'b0;
        a[1] = 64'd7;              b[1] = 64'd7;   c[1] = ALU_SUB;    s[1] = 1'b0; e[1] = 64'd0;                  z[1] = 1'b1;
        a[2] = 64'd3;              b[2] = 64'd100; c[2] = ALU_SH2ADD; s[2] = 1'b0; e[2] = 64'd112;                z[2] = 1'b0;
        a[3] = '1;                 b[3] = 64'd1;   c[3] = ALU_SLT;    s[3] = 1'b0; e[3] = 64'd1;                  z[3] = 1'b0;
        a[4] = 64'h8000_0000_0000_0000; b[4] = 64'd4; c[4] = ALU_SRA; s[4] = 1'b1; e[4] = 64'hF800_0000_0000_0000; z[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            RD1_E = a[i];
            ALUSrc_E = s[i];
            if (s[i]) begin ImmExt_E = b[i]; RD2_E = 64'hDEAD; end
            else      begin RD2_E = b[i]; ImmExt_E = 64'hBEEF; end
            ALUControl_E = c[i];
            @(negedge clk);
            n_vec++;
            if (ALUResult_E !== e[i] || Zero_E !== z[i]) begin
                n_bad++;
                $display("FAIL alu_%0d: got %h zero=%b expected %h zero=%b", i, ALUResult_E, Zero_E, e[i], z[i]);
            end
        end
        n_vec++;
        if (WriteData_E !== 64'hDEAD) begin
            n_bad++; $display("FAIL writedata: got %h expected %h", WriteData_E, 64'hDEAD);
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        logic [2:0]  op [6];
        logic [63:0] a  [6];
        logic [63:0] b  [6];
        logic        e  [6];
        op[0] = 3'b101; a[0] = 64'hFFFF_FFFF_FFFF_FFFB; b[0] = 64'd3; e[0] = 1'b0;
        op[1] = 3'b111; a[1] = 64'hFFFF_FFFF_FFFF_FFFB; b[1] = 64'd3; e[1] = 1'b1;
        op[2] = 3'b000; a[2] = 64'd42;  b[2] = 64'd42; e[2] = 1'b1;
        op[3] = 3'b100; a[3] = 64'hFFFF_FFFF_FFFF_FFFB; b[3] = 64'd3; e[3] = 1'b1;
        op[4] = 3'b110; a[4] = 64'hFFFF_FFFF_FFFF_FFFB; b[4] = 64'd3; e[4] = 1'b0;
        op[5] = 3'b010; a[5] = 64'd1;   b[5] = 64'd1;  e[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            Branch_E = 1'b1; BranchOp_E = op[i]; RD1_E = a[i]; RD2_E = b[i];
            PC_E = 64'h2000; ImmExt_E = 64'h40;
            @(negedge clk);
            n_vec++;
            if (PCSrc_E !== e[i] || PCTarget_E !== 64'h2040) begin
                n_bad++;
                $display("FAIL branch_%0d: got pcsrc=%b tgt=%h expected pcsrc=%b tgt=%h", i, PCSrc_E, PCTarget_E, e[i], 64'h2040);
            end
        end
        clear_inputs();
    endtask

    task automatic test_jump();
        @(posedge clk); #1;
        Jump_E = 1'b1; JumpReg_E = 1'b1; RD1_E = 64'h1001; ImmExt_E = 64'h10; PC_E = 64'h8000;
        @(negedge clk);
        n_vec++;
        if (PCTarget_E !== 64'h1010 || PCSrc_E !== 1'b1) begin
            n_bad++; $display("FAIL jalr: got tgt=%h pcsrc=%b expected tgt=%h pcsrc=1", PCTarget_E, PCSrc_E, 64'h1010);
        end
        @(posedge clk); #1;
        JumpReg_E = 1'b0; PC_E = 64'h8000; ImmExt_E = 64'hFFFF_FFFF_FFFF_FFF0;
        @(negedge clk);
        n_vec++;
        if (PCTarget_E !== 64'h7FF0 || PCSrc_E !== 1'b1) begin
            n_bad++; $display("FAIL jal: got tgt=%h pcsrc=%b expected tgt=%h pcsrc=1", PCTarget_E, PCSrc_E, 64'h7FF0);
        end
        clear_inputs();
    endtask

    task automatic test_mul();
        int          st;
        logic [63:0] r;
        logic [2:0]  op [4];
        logic [63:0] a  [4];
        logic [63:0] b  [4];
        logic [63:0] e  [4];
        op[0] = OP_MULH;   a[0] = 64'hFFFF_FFFF_FFFF_FFFE; b[0] = 64'd3; e[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        op[1] = OP_MUL;    a[1] = 64'hFFFF_FFFF_FFFF_FFFE; b[1] = 64'd3; e[1] = 64'hFFFF_FFFF_FFFF_FFFA;
        op[2] = OP_MULHU;  a[2] = '1;                      b[2] = '1;    e[2] = 64'hFFFF_FFFF_FFFF_FFFE;
        op[3] = OP_MULHSU; a[3] = '1;                      b[3] = 64'd2; e[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            run_mdu(op[i], a[i], b[i], (i == 0), st, r);
            n_vec++;
            if (st !== 65 || r !== e[i]) begin
                n_bad++; $display("FAIL mul_%0d: got stalls=%0d res=%h expected stalls=65 res=%h", i, st, r, e[i]);
            end
            mdu_stop();
        end
    endtask

    task automatic test_div_special();
        int          st;
        logic [63:0] r;
        logic [2:0]  op [4];
        logic [63:0] a  [4];
        logic [63:0] b  [4];
        logic [63:0] e  [4];
        op[0] = OP_DIV; a[0] = 64'd7;                    b[0] = 64'd0; e[0] = '1;
        op[1] = OP_REM; a[1] = 64'd7;                    b[1] = 64'd0; e[1] = 64'd7;
        op[2] = OP_DIV; a[2] = 64'h8000_0000_0000_0000; b[2] = '1;    e[2] = 64'h8000_0000_0000_0000;
        op[3] = OP_REM; a[3] = 64'h8000_0000_0000_0000; b[3] = '1;    e[3] = 64'd0;
        for (int i = 0; i < 4; i++) begin
            run_mdu(op[i], a[i], b[i], 1'b0, st, r);
            n_vec++;
            if (st !== 1 || r !== e[i]) begin
                n_bad++; $display("FAIL divspec_%0d: got stalls=%0d res=%h expected stalls=1 res=%h", i, st, r, e[i]);
            end
            mdu_stop();
        end
    endtask

    task automatic test_div_signed();
        int          st;
        logic [63:0] r;
        run_mdu(OP_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b0, st, r);
        n_vec++;
        if (st !== 65 || r !== 64'hFFFF_FFFF_FFFF_FFF2) begin
            n_bad++; $display("FAIL div_neg: got stalls=%0d res=%h expected stalls=65 res=%h", st, r, 64'hFFFF_FFFF_FFFF_FFF2);
        end
        mdu_stop();
        run_mdu(OP_REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b0, st, r);
        n_vec++;
        if (st !== 65 || r !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            n_bad++; $display("FAIL rem_neg: got stalls=%0d res=%h expected stalls=65 res=%h", st, r, 64'hFFFF_FFFF_FFFF_FFFE);
        end
        mdu_stop();
    endtask

    task automatic test_back_to_back();
        int          st;
        logic [63:0] r;
        run_mdu(OP_DIVU, 64'd100, 64'd7, 1'b0, st, r);
        n_vec++;
        if (st !== 65 || r !== 64'd14) begin
            n_bad++; $display("FAIL b2b_divu: got stalls=%0d res=%h expected stalls=65 res=%h", st, r, 64'd14);
        end
        run_mdu(OP_REMU, 64'd100, 64'd7, 1'b0, st, r);
        n_vec++;
        if (st !== 65 || r !== 64'd2) begin
            n_bad++; $display("FAIL b2b_remu: got stalls=%0d res=%h expected stalls=65 res=%h", st, r, 64'd2);
        end
        mdu_stop();
    endtask

    task automatic test_reset_mid_op();
        int          st;
        logic [63:0] r;
        @(posedge clk); #1;
        MDUOp_E = OP_DIV; RD1_E = 64'd1000; RD2_E = 64'd3; MDUStart_E = 1'b1;
        st = 0;
        for (int i = 0; i < 200 && st < 20; i++) begin
            @(negedge clk);
            if (Stall_E) st++;
        end
        @(posedge clk); #1;
        rst_n = 1'b0; MDUStart_E = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (Stall_E !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_stall0: got %b expected 0", Stall_E);
        end
        @(posedge clk); #1;
        MDUStart_E = 1'b1;
        @(negedge clk);
        n_vec++;
        if (Stall_E !== 1'b1) begin
            n_bad++; $display("FAIL rst_mid_stall1: got %b expected 1", Stall_E);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; MDUStart_E = 1'b0;
        run_mdu(OP_DIV, 64'd1000, 64'd3, 1'b0, st, r);
        n_vec++;
        if (st !== 65 || r !== 64'd333) begin
            n_bad++; $display("FAIL rst_mid_fresh: got stalls=%0d res=%h expected stalls=65 res=%h", st, r, 64'd333);
        end
        mdu_stop();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_jump();
        test_mul();
        test_div_special();
        test_div_signed();
        test_back_to_back();
        test_reset_mid_op();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/execute_m.md
# execute_m

Parametrised RV64IM execute stage. It replaces the single-cycle EX block with a full funct3 branch comparator and JALR target generation, plus an iterative multiply/divide unit (MDU) that stalls the pipeline while it runs. It sits between the ID/EX and EX/MEM registers and drives the hazard unit's EX stall input.

## Interface
- XLEN, 64, datapath width; must be a power of two ≥ 32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- RD1_E, RD2_E, ImmExt_E, PC_E  in  XLEN each  operands from ID/EX.
- ALUControl_E  in  4  existing ALU op, including Zba ops.
- ALUSrc_E  in  1  selects SrcB: 1 = ImmExt_E, 0 = RD2_E.
- Branch_E, Jump_E  in  1 each  conditional branch; JAL or JALR.
- JumpReg_E  in  1  JALR; target is register-relative.
- BranchOp_E  in  3  branch funct3.
- MDUStart_E  in  1  an M-extension op is in EX.
- MDUOp_E  in  3  M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- ALUResult_E  out  XLEN  ALU result, or MDU result in the DONE cycle.
- WriteData_E  out  XLEN  equals RD2_E.
- PCTarget_E  out  XLEN  branch or jump target.
- PCSrc_E  out  1  redirect fetch.
- Zero_E  out  1  ALU zero flag.
- Stall_E  out  1  hold PC, IF/ID and ID/EX; bubble EX/MEM.

## Operation
- Branch condition by BranchOp_E:
  - 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE.
  - 010 and 011 evaluate to false.
- PCSrc_E = Jump_E | (Branch_E & cond).
- PCTarget_E = JumpReg_E ? ((RD1_E + ImmExt_E) & ~1) : (PC_E + ImmExt_E).
- MDU FSM states:
  - IDLE, on MDUStart_E: if divide-by-zero or signed overflow → DONE; else if a multiply → MUL; else → DIV. Operands are latched as magnitudes; result sign and high/low select are latched with them.
  - MUL: shift-add, one bit per cycle, XLEN cycles, 2·XLEN-bit product; then → DONE.
  - DIV: restoring division, one bit per cycle, XLEN cycles; then → DONE.
  - DONE: result register holds the signed-corrected value; → IDLE unconditionally.
- Results:
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits with RISC-V signedness.
  - Divide by zero: quotient all-ones; remainder = dividend.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = dividend; remainder 0.
- Stall_E = (IDLE & MDUStart_E) | MUL | DIV. It is low in DONE, so ID/EX advances on that edge.
- The MDU starts only from IDLE. MDUStart_E held high in DONE does not restart it. A back-to-back M-op is seen in the next IDLE cycle.
- ALUResult_E carries the MDU result only in DONE; otherwise it carries the ALU result.

## Timing
- Reset values:
  - FSM in IDLE; counter 0; MDU result register 0.
  - Stall_E 0 whenever MDUStart_E is 0.
  - All other outputs are combinational from inputs.
- ALU, branch, jump, PCTarget_E and PCSrc_E: zero latency, same cycle.
- Normal MUL/DIV: XLEN+1 stall cycles (the IDLE start cycle plus XLEN iterations). The result appears in the DONE cycle, so the instruction occupies EX for XLEN+2 cycles.
- Special-case divide: 1 stall cycle; result in the following DONE cycle.
- rst_n low mid-operation: next edge returns to IDLE and discards partial state. Stall_E then follows MDUStart_E.
- Operand inputs may change during MUL or DIV without effect; only the latched copies are used.

## Structure
- Package execute_m_pkg holds:
  - mdu_op_e, encoding funct3 values.
  - mdu_state_e: IDLE, MUL, DIV, DONE.
  - branch_op constants BEQ, BNE, BLT, BGE, BLTU, BGEU.
- Sub-module mdu (parameter XLEN) contains the FSM, counter, operand, accumulator and result registers. It has a start/op input and busy/done/result outputs.
- The existing alu is instantiated unchanged. The comparator and target adder live in execute_m.

## Test plan
- BranchOp_E=101, Branch_E=1, RD1=−5, RD2=3 → PCSrc_E=0. Same operands with 111 → PCSrc_E=1 (0xFFFF…FFFB ≥ 3 unsigned).
- JumpReg_E=1, Jump_E=1, RD1=0x1001, Imm=0x10 → PCTarget_E=0x1010, PCSrc_E=1 in the same cycle.
- MULH, RD1=−2, RD2=3, MDUStart_E held → Stall_E high for exactly 65 cycles; DONE-cycle ALUResult_E=0xFFFF_FFFF_FFFF_FFFF. MUL with the same operands → 0xFFFF…FFFA.
- DIV 7/0 → Stall_E for 1 cycle; result all-ones. REM 7/0 → 7. DIV of 0x8000…0000 by −1 → 0x8000…0000. REM of the same → 0.
- Back-to-back DIVU 100/7 then REMU 100/7 → results 14 and 2. Each stalls 65 cycles with one non-stall DONE cycle between.
- rst_n low during iteration 20 of a DIV → next cycle FSM in IDLE, Stall_E=MDUStart_E. A fresh DIV after reset gives the correct quotient.
